// File: rtl/fios_res_collector.sv
// Collects LSW-first 17-bit result words from the FIOS multiplier into one parallel result.
// Define FIOS_FINAL_SUB_EN to add the word-serial final subtraction of p_i and the SELECT state.
module fios_res_collector #(
  parameter int s = 8
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [16:0]     RES_i,
  input  logic            RES_valid_i,
  input  logic [17*s-1:0] p_i,
  output logic [17*s-1:0] res_o,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic            busy_o,
  output logic            error_o
);

  localparam int CW = (s > 1) ? $clog2(s) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(s - 1);
  localparam logic [CW-1:0] ZERO_IDX = {CW{1'b0}};
  localparam logic [17*s-1:0] ZERO_BANK = {(17*s){1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SELECT  = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [s-1:0][16:0]   word_q, word_d;
  logic [17*s-1:0]      res_q, res_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;

  logic                 store_s;
  logic                 last_s;
  logic                 overflow_s;
  logic [CW-1:0]        wr_idx_s;

  // Word 0 always lands at index 0 regardless of the stale counter value.
  assign wr_idx_s   = (state_q == IDLE) ? ZERO_IDX : cnt_q;
  assign store_s    = RES_valid_i && ((state_q == IDLE) || (state_q == CAPTURE));
  assign last_s     = store_s && (wr_idx_s == LAST_IDX);
  assign overflow_s = RES_valid_i && ((state_q == SELECT) || (state_q == HOLD));

`ifdef FIOS_FINAL_SUB_EN
  logic [s-1:0][16:0]   diff_q, diff_d;
  logic                 borrow_q, borrow_d;
  logic                 borrow_in_s;
  logic [16:0]          p_word_s;
  logic [17:0]          diff_full_s;

  assign borrow_in_s = (state_q == IDLE) ? 1'b0 : borrow_q;
  assign p_word_s    = p_i[17*int'(wr_idx_s) +: 17];
  assign diff_full_s = {1'b0, RES_i} - {1'b0, p_word_s} - {17'd0, borrow_in_s};

  // Serial subtraction: one diff word and the running borrow per stored word.
  always_comb begin
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (store_s) begin
      diff_d[wr_idx_s] = diff_full_s[16:0];
      borrow_d         = diff_full_s[17];
    end else begin
      borrow_d = borrow_q;
    end
  end

  // Diff bank and borrow registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      diff_q   <= ZERO_BANK;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end
`else
  logic unused_p_s;
  assign unused_p_s = ^p_i;
`endif

  // Capture control, word bank update and result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    res_d   = res_q;
    error_d = error_q | overflow_s;

    if (store_s) begin
      word_d[wr_idx_s] = RES_i;
      if (last_s) begin
        cnt_d = ZERO_IDX;
      end else begin
        cnt_d = wr_idx_s + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      IDLE, CAPTURE: begin
        if (last_s) begin
`ifdef FIOS_FINAL_SUB_EN
          state_d = SELECT;
`else
          state_d = HOLD;
          res_d   = word_d;
`endif
        end else if (store_s) begin
          state_d = CAPTURE;
        end else begin
          state_d = state_q;
        end
      end
`ifdef FIOS_FINAL_SUB_EN
      SELECT: begin
        // A final borrow means the raw value was already below p.
        res_d   = borrow_q ? word_q : diff_q;
        state_d = HOLD;
      end
`endif
      HOLD: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    res_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  // State, word bank and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= ZERO_IDX;
      word_q      <= ZERO_BANK;
      res_q       <= ZERO_BANK;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = busy_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Self-checking bench for fios_res_collector: s=2 and s=4 instances, directed table plus random stream.
// Expectations follow FIOS_FINAL_SUB_EN (reduced result, latency 2) or its absence (raw, latency 1).
module tb_fios_res_collector;

`ifdef FIOS_FINAL_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  localparam int LAT = SUB ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst, vld, sel, ready;
  logic [16:0] word;
  logic [33:0] p2;
  logic [67:0] p4;
  logic [33:0] res2;
  logic [67:0] res4;
  logic        v2, v4, b2, b4, e2, e4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fios_res_collector #(.s(2)) u_s2 (
    .clock_i(clk), .reset_i(rst), .RES_i(word), .RES_valid_i(vld & ~sel),
    .p_i(p2), .res_o(res2), .res_valid_o(v2), .res_ready_i(ready),
    .busy_o(b2), .error_o(e2)
  );

  fios_res_collector #(.s(4)) u_s4 (
    .clock_i(clk), .reset_i(rst), .RES_i(word), .RES_valid_i(vld & sel),
    .p_i(p4), .res_o(res4), .res_valid_o(v4), .res_ready_i(ready),
    .busy_o(b4), .error_o(e4)
  );

  typedef struct {
    int               ns;
    logic [3:0][16:0] w;
    int               gap;
    logic [67:0]      p;
    logic [67:0]      exp_sub;
    logic [67:0]      exp_raw;
  } vec_t;

  vec_t vt [5];

  function automatic logic [67:0] get_res();
    return sel ? res4 : {34'd0, res2};
  endfunction

  function automatic logic get_valid();
    return sel ? v4 : v2;
  endfunction

  function automatic logic get_busy();
    return sel ? b4 : b2;
  endfunction

  function automatic logic [3:0][16:0] mkw(input logic [16:0] a, input logic [16:0] b,
                                            input logic [16:0] c, input logic [16:0] d);
    return {d, c, b, a};
  endfunction

  // Reference: integer value of the word stream, minus p once if it reaches p.
  function automatic logic [67:0] model(input int ns, input logic [3:0][16:0] w, input logic [67:0] p);
    logic [67:0] v;
    v = 68'd0;
    for (int k = 0; k < ns; k++) v = v + ({51'd0, w[k]} << (17 * k));
    if (SUB && (v >= p)) v = v - p;
    return v;
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string name, input int ns, input logic [3:0][16:0] w,
                         input int gap, input logic [67:0] exp);
    int cyc;
    sel   = (ns == 4);
    ready = 1'b1;
    for (int k = 0; k < ns; k++) begin
      vld  = 1'b1;
      word = w[k];
      @(negedge clk);
      vld  = 1'b0;
      word = 17'd0;
      if (k == 0) check({name, "_busy"}, 68'(get_busy()), 68'd1);
      if (k < ns - 1) repeat (gap) @(negedge clk);
    end
    cyc = 0;
    while (!get_valid() && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 68'(cyc), 68'(LAT - 1));
    check({name, "_res"}, get_res(), exp);
    @(negedge clk);
    check({name, "_valid_busy_drop"}, {66'd0, get_valid(), get_busy()}, 68'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0][16:0] w;
    logic [67:0]      p, exp;
    int               ns, cyc;

    vt[0] = '{2, mkw(17'h7, 17'h0, 17'h0, 17'h0), 0, 68'h5, 68'h2, 68'h7};
    vt[1] = '{2, mkw(17'h3, 17'h0, 17'h0, 17'h0), 0, 68'h5, 68'h3, 68'h3};
    vt[2] = '{2, mkw(17'h5, 17'h0, 17'h0, 17'h0), 0, 68'h5, 68'h0, 68'h5};
    vt[3] = '{4, mkw(17'h0, 17'h2, 17'h0, 17'h0), 3, 68'h20000, 68'h20000, 68'h40000};
    vt[4] = '{4, mkw(17'h0, 17'h1, 17'h0, 17'h0), 3, 68'h1, 68'h1FFFF, 68'h20000};

    rst = 1'b1; vld = 1'b0; sel = 1'b0; ready = 1'b0; word = 17'd0; p2 = 34'd0; p4 = 68'd0;
    repeat (2) @(negedge clk);
    check("reset_s2", {res2, v2, b2, e2}, 68'd0);
    check("reset_s4", res4, 68'd0);
    check("reset_s4_flags", {65'd0, v4, b4, e4}, 68'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      p2 = vt[i].p[33:0];
      p4 = vt[i].p;
      run_txn($sformatf("vec%0d", i), vt[i].ns, vt[i].w, vt[i].gap,
              SUB ? vt[i].exp_sub : vt[i].exp_raw);
    end

    for (int i = 0; i < 30; i++) begin
      ns = ($urandom_range(0, 1) == 1) ? 4 : 2;
      p  = 68'd0;
      w  = {68{1'b0}};
      for (int k = 0; k < ns; k++) begin
        p[17*k +: 17] = 17'($urandom);
        w[k]          = 17'($urandom);
      end
      if (p == 68'd0) p = 68'd1;
      if ($urandom_range(0, 3) == 0) w = p;
      p2  = p[33:0];
      p4  = p;
      exp = model(ns, w, p);
      run_txn($sformatf("rnd%0d", i), ns, w, $urandom_range(0, 2), exp);
    end
    check("no_error_yet", {66'd0, e2, e4}, 68'd0);

    // Backpressure with an overflow pulse while holding.
    sel = 1'b1; ready = 1'b0;
    p4  = {17'h00001, 17'h0ABCD, 17'h12345, 17'h00777};
    w   = mkw(17'h00800, 17'h12345, 17'h0ABCD, 17'h00002);
    exp = model(4, w, p4);
    for (int k = 0; k < 4; k++) begin
      vld = 1'b1; word = w[k];
      @(negedge clk);
      vld = 1'b0; word = 17'd0;
    end
    cyc = 0;
    while (!v4 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", 68'(cyc), 68'(LAT - 1));
    check("bp_res", res4, exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 68'(v4), 68'd1);
      check("bp_res_held", res4, exp);
    end
    vld = 1'b1; word = 17'h1ABCD;
    @(negedge clk);
    vld = 1'b0; word = 17'd0;
    check("ovf_error", 68'(e4), 68'd1);
    check("ovf_res_kept", res4, exp);
    check("ovf_valid_kept", 68'(v4), 68'd1);
    ready = 1'b1;
    @(negedge clk);
    check("bp_done", {66'd0, v4, b4}, 68'd0);
    check("ovf_sticky", 68'(e4), 68'd1);

    // Reset in the middle of a capture, then a fresh stream.
    for (int k = 0; k < 2; k++) begin
      vld = 1'b1; word = 17'h1FFFF;
      @(negedge clk);
      vld = 1'b0; word = 17'd0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_res", res4, 68'd0);
    check("midrst_flags", {65'd0, v4, b4, e4}, 68'd0);
    rst = 1'b0;
    p4  = {17'h00000, 17'h00010, 17'h00000, 17'h00005};
    w   = mkw(17'h00001, 17'h00002, 17'h00003, 17'h00000);
    run_txn("post_rst", 4, w, 1, model(4, w, p4));
    check("post_rst_error", 68'(e4), 68'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
